// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing multiplier sequencer.
package sc_pkg;

    localparam int SC_WIDTH = 8;

    localparam logic [7:0] SEED_A = 8'h01;
    localparam logic [7:0] SEED_B = 8'hF4;
    localparam logic [7:0] TAP_A  = 8'h8E;  // x^8+x^4+x^3+x^2+1
    localparam logic [7:0] TAP_B  = 8'hB8;  // x^8+x^6+x^5+x^4+1

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_state_t;

endpackage

// File: rtl/sc_lfsr.sv
// Fibonacci LFSR, shift-left form. Seed is restored on reset and on load.
module sc_lfsr
    import sc_pkg::*;
#(
    parameter int               WIDTH = SC_WIDTH,
    parameter logic [WIDTH-1:0] TAP   = WIDTH'(TAP_A),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(SEED_A)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[WIDTH-2:0], ^(q & TAP)};
        end
    end

endmodule

// File: rtl/sc_mul_seq.sv
// Sequencer for the SC multiplier: accepts an operand pair, runs one full LFSR
// period of AND-ed comparator streams and returns the ones count.
module sc_mul_seq
    import sc_pkg::*;
#(
    parameter int WIDTH = SC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam int               LEN      = 2**WIDTH - 1;
    localparam logic [WIDTH-1:0] LAST_CYC = WIDTH'(LEN - 1);

    sc_state_t        state_reg;
    sc_state_t        state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] cyc_reg;
    logic [WIDTH-1:0] lfsr_a;
    logic [WIDTH-1:0] lfsr_b;
    logic             accept;
    logic             running;
    logic             bit_a;
    logic             bit_b;

    assign accept  = (state_reg == IDLE) && in_valid;
    assign running = (state_reg == RUN);
    assign bit_a   = (a_reg > lfsr_a);
    assign bit_b   = (b_reg > lfsr_b);

    sc_lfsr #(
        .WIDTH (WIDTH),
        .TAP   (WIDTH'(TAP_A)),
        .SEED  (WIDTH'(SEED_A))
    ) u_lfsr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .en    (running),
        .q     (lfsr_a)
    );

    sc_lfsr #(
        .WIDTH (WIDTH),
        .TAP   (WIDTH'(TAP_B)),
        .SEED  (WIDTH'(SEED_B))
    ) u_lfsr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .en    (running),
        .q     (lfsr_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // abort wins over both completion and the output handshake
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (in_valid) state_next = RUN;
            RUN: begin
                if (abort)                     state_next = IDLE;
                else if (cyc_reg == LAST_CYC)  state_next = DONE;
            end
            DONE: begin
                if (abort)          state_next = IDLE;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            cyc_reg <= '0;
        end else if (accept) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            acc_reg <= '0;
            cyc_reg <= '0;
        end else if (running) begin
            acc_reg <= acc_reg + {{(WIDTH-1){1'b0}}, bit_a & bit_b};
            cyc_reg <= cyc_reg + 1'b1;
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);
    assign out_result = acc_reg;

endmodule

// File: tb/tb_sc_mul_seq.sv
// Directed and randomized bench for sc_mul_seq against a stream-counting model.
module tb_sc_mul_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       abort;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       busy;

    int checks = 0;
    int errors = 0;

    sc_mul_seq #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Count of cycles over one full period in which both comparator bits are 1.
    function automatic int model(input int a, input int b);
        logic [7:0] la;
        logic [7:0] lb;
        int         cnt;
        la  = 8'h01;
        lb  = 8'hF4;
        cnt = 0;
        for (int i = 0; i < 255; i++) begin
            if ((a > int'(la)) && (b > int'(lb))) cnt++;
            la = {la[6:0], ^(la & 8'h8E)};
            lb = {lb[6:0], ^(lb & 8'hB8)};
        end
        return cnt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic start_job(input int a, input int b);
        in_a     = 8'(a);
        in_b     = 8'(b);
        in_valid = 1'b1;
        chk("accept_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit noise, output int lat);
        lat = 0;
        while (!out_valid && lat < 400) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a     = 8'($urandom);
                in_b     = 8'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("take_in_ready", 32'(in_ready), 1);
        chk("take_out_valid", 32'(out_valid), 0);
    endtask

    task automatic run_job(input string tag, input int a, input int b, output int res);
        int lat;
        start_job(a, b);
        wait_done(1'b0, lat);
        chk({tag, "_latency"}, 32'(lat), 255);
        res = int'(out_result);
        chk({tag, "_result"}, 32'(res), 32'(model(a, b)));
        $display("job %s a=%0d b=%0d result=%0d latency=%0d", tag, a, b, res, lat);
        take_result();
    endtask

    initial begin
        int res;
        int res0;
        int lat;
        int seen;
        int ra;
        int rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_result", 32'(out_result), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero / one operands
        run_job("zero", 0, 255, res);
        chk("zero_const", 32'(res), 0);
        run_job("one", 1, 200, res);
        chk("one_const", 32'(res), 0);

        // Accuracy with in_valid noise during RUN and DONE, and a held result
        start_job(224, 239);
        wait_done(1'b1, lat);
        chk("acc_latency", 32'(lat), 255);
        res0 = int'(out_result);
        chk("acc_result", 32'(res0), 32'(model(224, 239)));
        chk("acc_range", 32'((res0 >= 189) && (res0 <= 231)), 1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_out_result", 32'(out_result), 32'(res0));
        end
        in_valid = 1'b0;
        $display("job hold a=224 b=239 result=%0d", res0);
        take_result();

        run_job("full", 255, 255, res);
        chk("full_range", 32'((res >= 253) && (res <= 254)), 1);

        for (int i = 0; i < 3; i++) begin
            ra = int'($urandom_range(0, 255));
            rb = int'($urandom_range(0, 255));
            run_job("rand", ra, rb, res);
        end

        // Back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        start_job(128, 128);
        in_valid = 1'b1;
        in_a     = 8'd64;
        in_b     = 8'd192;
        lat = 0;
        while (!out_valid && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("b2b1_latency", 32'(lat), 255);
        chk("b2b1_result", 32'(out_result), 32'(model(128, 128)));
        $display("job b2b1 a=128 b=128 result=%0d latency=%0d", out_result, lat);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_gap_in_ready", 32'(in_ready), 1);
        chk("b2b_gap_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b2_accepted", 32'(busy), 1);
        wait_done(1'b0, lat);
        chk("b2b2_latency", 32'(lat), 255);
        chk("b2b2_result", 32'(out_result), 32'(model(64, 192)));
        $display("job b2b2 a=64 b=192 result=%0d latency=%0d", out_result, lat);
        take_result();

        // Abort at cyc=100
        start_job(200, 200);
        repeat (100) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_run_busy", 32'(busy), 0);
        chk("abort_run_in_ready", 32'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_run_no_result", 32'(seen), 0);
        $display("job abort_run a=200 b=200 aborted");

        // Abort together with out_ready in DONE
        start_job(100, 150);
        wait_done(1'b0, lat);
        chk("abort_done_latency", 32'(lat), 255);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        chk("abort_done_in_ready", 32'(in_ready), 1);
        chk("abort_done_out_valid", 32'(out_valid), 0);
        $display("job abort_done a=100 b=150 aborted");

        // abort ignored in IDLE; in_valid still accepted
        ra       = int'($urandom_range(0, 255));
        rb       = int'($urandom_range(0, 255));
        in_a     = 8'(ra);
        in_b     = 8'(rb);
        in_valid = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        chk("idle_abort_accepted", 32'(busy), 1);
        wait_done(1'b0, lat);
        chk("post_abort_latency", 32'(lat), 255);
        chk("post_abort_result", 32'(out_result), 32'(model(ra, rb)));
        $display("job post_abort a=%0d b=%0d result=%0d latency=%0d", ra, rb, out_result, lat);
        take_result();

        // Reset mid-RUN
        start_job(50, 60);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 1);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_out_result", 32'(out_result), 0);
        chk("midrst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_ready", 32'(in_ready), 1);
        run_job("postrst", 224, 239, res);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
